// File: rtl/fifo_mc_pkg.sv
// Shared helpers and constants for the single-clock multi-channel FIFO.
package fifo_mc_pkg;

   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned ch_w(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Pointer type for the default 16-entry channel; the wrap bit sits above the address bits.
   localparam int unsigned DEF_DEPTH = 16;
   typedef logic [$clog2(DEF_DEPTH):0] ptr_t;

   localparam logic FLAG_SET = 1'b1;
   localparam logic FLAG_CLR = 1'b0;

endpackage

// File: rtl/fifo_mc_mem_if.sv
// Write/read request and status bundle of fifo_mc_mem; almost flags exist only with FIFO_MC_ALMOST_FLAGS_EN.
interface fifo_mc_mem_if #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned CH_SIZE   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic                 w_en;
   logic [CH_SIZE-1:0]   w_ch;
   logic [DATA_SIZE-1:0] data_in;
   logic                 r_en;
   logic [CH_SIZE-1:0]   r_ch;
   logic [DATA_SIZE-1:0] data_out;
   logic                 r_valid;
   logic [NUM_CH-1:0]    full;
   logic [NUM_CH-1:0]    empty;
   logic                 write_error;
   logic                 read_error;
`ifdef FIFO_MC_ALMOST_FLAGS_EN
   logic [NUM_CH-1:0]    almost_full;
   logic [NUM_CH-1:0]    almost_empty;
`endif

   modport master (
`ifdef FIFO_MC_ALMOST_FLAGS_EN
      input  almost_full, almost_empty,
`endif
      output w_en, w_ch, data_in, r_en, r_ch,
      input  data_out, r_valid, full, empty, write_error, read_error
   );

   modport slave (
`ifdef FIFO_MC_ALMOST_FLAGS_EN
      output almost_full, almost_empty,
`endif
      input  w_en, w_ch, data_in, r_en, r_ch,
      output data_out, r_valid, full, empty, write_error, read_error
   );

endinterface

// File: rtl/fifo_ch_ctrl.sv
// One channel's write/read pointers with full/empty decode; FIFO_MC_ALMOST_FLAGS_EN adds registered almost flags.
module fifo_ch_ctrl import fifo_mc_pkg::*; #(
   parameter int unsigned PTR_SIZE = 4
`ifdef FIFO_MC_ALMOST_FLAGS_EN
   ,
   parameter int unsigned AF_LEVEL = (1 << PTR_SIZE) - 2,
   parameter int unsigned AE_LEVEL = 2
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_inc,
   input  logic              rd_inc,
   output logic [PTR_SIZE:0] wptr,
   output logic [PTR_SIZE:0] rptr,
   output logic              full,
   output logic              empty
`ifdef FIFO_MC_ALMOST_FLAGS_EN
   ,
   output logic              almost_full,
   output logic              almost_empty
`endif
);

   localparam int unsigned PW = PTR_SIZE + 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_inc) wptr <= wptr + PW'(1);
         if (rd_inc) rptr <= rptr + PW'(1);
      end
   end

   // Same low bits: equal wrap bits means empty, opposite wrap bits means full.
   assign empty = (wptr == rptr);
   assign full  = (wptr[PTR_SIZE] != rptr[PTR_SIZE]) &&
                  (wptr[PTR_SIZE-1:0] == rptr[PTR_SIZE-1:0]);

`ifdef FIFO_MC_ALMOST_FLAGS_EN
   logic [PTR_SIZE:0] occ;

   assign occ = wptr - rptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         almost_full  <= FLAG_CLR;
         almost_empty <= FLAG_SET;
      end else begin
         almost_full  <= (32'(occ) >= AF_LEVEL);
         almost_empty <= (32'(occ) <= AE_LEVEL);
      end
   end
`endif

endmodule

// File: rtl/fifo_mc_mem.sv
// NUM_CH logical FIFOs sharing one storage array, one clock; FIFO_MC_ALMOST_FLAGS_EN adds almost_full/almost_empty.
module fifo_mc_mem import fifo_mc_pkg::*; #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned PTR_SIZE  = ptr_w(DEPTH),
   parameter int unsigned CH_SIZE   = ch_w(NUM_CH),
   parameter int unsigned AF_LEVEL  = DEPTH - 2,
   parameter int unsigned AE_LEVEL  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   fifo_mc_mem_if.slave  bus
);

   localparam int unsigned PW      = PTR_SIZE + 1;
   localparam int unsigned CH_SPAN = 1 << CH_SIZE;
   localparam int unsigned AW      = CH_SIZE + PTR_SIZE;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PTR_SIZE != ptr_w(DEPTH) ||
       CH_SIZE != ch_w(NUM_CH) || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_cfg
      $error("fifo_mc_mem: inconsistent DEPTH/PTR_SIZE/CH_SIZE or almost-flag level");
   end

   logic [CH_SPAN-1:0]   full_v;
   logic [CH_SPAN-1:0]   empty_v;
   logic [PW-1:0]        wptr_v [CH_SPAN];
   logic [PW-1:0]        rptr_v [CH_SPAN];
   logic [NUM_CH-1:0]    wr_inc;
   logic [NUM_CH-1:0]    rd_inc;
   logic                 w_acc;
   logic                 r_acc;
   logic [AW-1:0]        waddr;
   logic [AW-1:0]        raddr;
   logic [DATA_SIZE-1:0] mem [CH_SPAN*DEPTH];
   logic [DATA_SIZE-1:0] data_out_q;
   logic                 r_valid_q;
   logic                 write_error_q;
   logic                 read_error_q;
`ifdef FIFO_MC_ALMOST_FLAGS_EN
   logic [NUM_CH-1:0]    af_v;
   logic [NUM_CH-1:0]    ae_v;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign wr_inc[c] = w_acc && (bus.w_ch == CH_SIZE'(c));
      assign rd_inc[c] = r_acc && (bus.r_ch == CH_SIZE'(c));

      fifo_ch_ctrl #(
         .PTR_SIZE (PTR_SIZE)
`ifdef FIFO_MC_ALMOST_FLAGS_EN
         ,
         .AF_LEVEL (AF_LEVEL),
         .AE_LEVEL (AE_LEVEL)
`endif
      ) u_ctrl (
         .clk          (clk),
         .rst_n        (rst_n),
         .wr_inc       (wr_inc[c]),
         .rd_inc       (rd_inc[c]),
         .wptr         (wptr_v[c]),
         .rptr         (rptr_v[c]),
         .full         (full_v[c]),
         .empty        (empty_v[c])
`ifdef FIFO_MC_ALMOST_FLAGS_EN
         ,
         .almost_full  (af_v[c]),
         .almost_empty (ae_v[c])
`endif
      );
   end

   // Unpopulated channel codes look permanently full and empty, so requests to them are rejected.
   for (genvar c = NUM_CH; c < CH_SPAN; c++) begin : g_pad
      assign full_v[c]  = 1'b1;
      assign empty_v[c] = 1'b1;
      assign wptr_v[c]  = '0;
      assign rptr_v[c]  = '0;
   end

   assign w_acc = bus.w_en & ~full_v[bus.w_ch];
   assign r_acc = bus.r_en & ~empty_v[bus.r_ch];
   assign waddr = {bus.w_ch, wptr_v[bus.w_ch][PTR_SIZE-1:0]};
   assign raddr = {bus.r_ch, rptr_v[bus.r_ch][PTR_SIZE-1:0]};

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_acc) mem[waddr] <= bus.data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_q    <= '0;
         r_valid_q     <= FLAG_CLR;
         write_error_q <= FLAG_CLR;
         read_error_q  <= FLAG_CLR;
      end else begin
         if (r_acc) data_out_q <= mem[raddr];
         r_valid_q     <= r_acc;
         write_error_q <= bus.w_en & ~w_acc;
         read_error_q  <= bus.r_en & ~r_acc;
      end
   end

   assign bus.data_out    = data_out_q;
   assign bus.r_valid     = r_valid_q;
   assign bus.write_error = write_error_q;
   assign bus.read_error  = read_error_q;
   assign bus.full        = full_v[NUM_CH-1:0];
   assign bus.empty       = empty_v[NUM_CH-1:0];
`ifdef FIFO_MC_ALMOST_FLAGS_EN
   assign bus.almost_full  = af_v;
   assign bus.almost_empty = ae_v;
`endif

endmodule

// File: tb/tb_fifo_mc_mem.sv
// Directed bench for fifo_mc_mem (4 channels x 16 entries x 8 bits).
module tb_fifo_mc_mem;

   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   fifo_mc_mem_if #(.NUM_CH(4), .DATA_SIZE(8), .CH_SIZE(2)) bus ();

   fifo_mc_mem #(.NUM_CH(4), .DEPTH(16), .DATA_SIZE(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Present one request set, clock it, and return 1 time unit after the edge.
   task automatic cyc(input int we, input int wc, input int d, input int re, input int rc);
      bus.w_en    = 1'(we);
      bus.w_ch    = 2'(wc);
      bus.data_in = 8'(d);
      bus.r_en    = 1'(re);
      bus.r_ch    = 2'(rc);
      @(posedge clk);
      #1;
      bus.w_en = 1'b0;
      bus.r_en = 1'b0;
   endtask

   initial begin
      logic [1:0] rch  [4];
      logic [7:0] rexp [4];

      rst_n       = 1'b0;
      bus.w_en    = 1'b0;
      bus.w_ch    = '0;
      bus.data_in = '0;
      bus.r_en    = 1'b0;
      bus.r_ch    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_empty", 32'(bus.empty), 32'hF);
      chk("rst_full", 32'(bus.full), 32'h0);
      chk("rst_data_out", 32'(bus.data_out), 32'h0);
      chk("rst_r_valid", 32'(bus.r_valid), 32'h0);
      chk("rst_write_error", 32'(bus.write_error), 32'h0);
      chk("rst_read_error", 32'(bus.read_error), 32'h0);
      rst_n = 1'b1;

      // single word through ch2
      cyc(1, 2, 'hA5, 0, 0);
      chk("a5_empty_after_write", 32'(bus.empty), 32'hB);
      chk("a5_no_valid_on_write", 32'(bus.r_valid), 32'h0);
      cyc(0, 0, 0, 1, 2);
      chk("a5_r_valid", 32'(bus.r_valid), 32'h1);
      chk("a5_data_out", 32'(bus.data_out), 32'hA5);
      chk("a5_empty_after_read", 32'(bus.empty), 32'hF);
      cyc(0, 0, 0, 0, 0);
      chk("a5_valid_drops", 32'(bus.r_valid), 32'h0);
      chk("a5_data_holds", 32'(bus.data_out), 32'hA5);

      // fill ch0, overflow, then read while full with a concurrent write
      for (int i = 0; i < 16; i++) cyc(1, 0, i, 0, 0);
      chk("fill_full", 32'(bus.full), 32'h1);
      chk("fill_empty", 32'(bus.empty), 32'hE);
      chk("fill_no_werr", 32'(bus.write_error), 32'h0);
      cyc(1, 0, 'h99, 0, 0);
      chk("ovf_write_error", 32'(bus.write_error), 32'h1);
      chk("ovf_full_kept", 32'(bus.full), 32'h1);
      chk("ovf_others_empty", 32'(bus.empty), 32'hE);
      cyc(0, 0, 0, 0, 0);
      chk("ovf_werr_clears", 32'(bus.write_error), 32'h0);
      cyc(1, 0, 'h77, 1, 0);
      chk("full_rw_write_error", 32'(bus.write_error), 32'h1);
      chk("full_rw_r_valid", 32'(bus.r_valid), 32'h1);
      chk("full_rw_data", 32'(bus.data_out), 32'h00);
      chk("full_rw_not_full", 32'(bus.full), 32'h0);
      for (int i = 1; i < 16; i++) begin
         cyc(0, 0, 0, 1, 0);
         chk("drain_data", 32'(bus.data_out), 32'(i));
         chk("drain_valid", 32'(bus.r_valid), 32'h1);
      end
      chk("drain_empty", 32'(bus.empty), 32'hF);

      // read-while-empty on ch1 with a concurrent write to ch1
      cyc(1, 1, 'h5C, 1, 1);
      chk("rwe_read_error", 32'(bus.read_error), 32'h1);
      chk("rwe_r_valid", 32'(bus.r_valid), 32'h0);
      chk("rwe_data_holds", 32'(bus.data_out), 32'h0F);
      chk("rwe_empty", 32'(bus.empty), 32'hD);
      cyc(0, 0, 0, 1, 1);
      chk("rwe_data", 32'(bus.data_out), 32'h5C);
      chk("rwe_valid", 32'(bus.r_valid), 32'h1);
      chk("rwe_rerr_clears", 32'(bus.read_error), 32'h0);

      // channel isolation between ch0 and ch3
      cyc(1, 0, 'h10, 0, 0);
      cyc(1, 3, 'h30, 0, 0);
      cyc(1, 0, 'h11, 0, 0);
      cyc(1, 3, 'h31, 0, 0);
      chk("iso_empty", 32'(bus.empty), 32'h6);
      rch  = '{2'd3, 2'd3, 2'd0, 2'd0};
      rexp = '{8'h30, 8'h31, 8'h10, 8'h11};
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1, int'(rch[i]));
         chk("iso_data", 32'(bus.data_out), 32'(rexp[i]));
         chk("iso_valid", 32'(bus.r_valid), 32'h1);
      end
      chk("iso_empty_after", 32'(bus.empty), 32'hF);

      // 40 words through ch1, one behind, across several pointer wraps
      cyc(1, 1, 'h80, 0, 0);
      for (int k = 1; k < 40; k++) begin
         cyc(1, 1, 'h80 + k, 1, 1);
         chk("wrap_data", 32'(bus.data_out), 32'('h80 + k - 1));
         chk("wrap_valid", 32'(bus.r_valid), 32'h1);
         chk("wrap_not_full", 32'(bus.full[1]), 32'h0);
      end
      cyc(0, 0, 0, 1, 1);
      chk("wrap_last", 32'(bus.data_out), 32'hA7);
      chk("wrap_empty", 32'(bus.empty), 32'hF);

      // independent channels: write ch2 while reading empty ch3
      cyc(1, 2, 'h42, 1, 3);
      chk("xch_read_error", 32'(bus.read_error), 32'h1);
      chk("xch_no_write_error", 32'(bus.write_error), 32'h0);
      chk("xch_data_holds", 32'(bus.data_out), 32'hA7);
      chk("xch_empty", 32'(bus.empty), 32'hB);
      cyc(0, 0, 0, 1, 2);
      chk("xch_data", 32'(bus.data_out), 32'h42);

      // asynchronous reset in the middle of a write burst
      for (int i = 0; i < 5; i++) cyc(1, 0, 'hC0 + i, 0, 0);
      chk("pre_rst_empty", 32'(bus.empty), 32'hE);
      bus.w_en    = 1'b1;
      bus.w_ch    = 2'd0;
      bus.data_in = 8'h66;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_empty", 32'(bus.empty), 32'hF);
      chk("async_rst_full", 32'(bus.full), 32'h0);
      chk("async_rst_data_out", 32'(bus.data_out), 32'h0);
      @(posedge clk);
      #1;
      chk("in_rst_empty", 32'(bus.empty), 32'hF);
      bus.w_en = 1'b0;
      rst_n    = 1'b1;
      cyc(0, 0, 0, 1, 0);
      chk("post_rst_read_error", 32'(bus.read_error), 32'h1);
      chk("post_rst_r_valid", 32'(bus.r_valid), 32'h0);
      chk("post_rst_data_out", 32'(bus.data_out), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
